load_extract_unit: RTL
======================

Name: load_extract_unit

Overview:
- Read-path counterpart of the store byte/halfword merge logic in the MIPS datapath.
- Accepts one load request at a time (LW/LB/LBU/LH/LHU) and issues a word-aligned read to data memory.
- Waits for the memory acknowledge, then extracts and sign- or zero-extends the addressed byte or halfword.
- Returns the result to writeback with a valid pulse. Misaligned accesses and memory timeouts are flagged instead of reading.

Parameters:
- TIMEOUT, 16, maximum cycles the unit waits for mem_ack before reporting bus_err; 0 disables the timeout.
- TAG_W, 5, width of the destination-register tag carried with each request.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_addr  input  32  byte address.
- lsb  input  1  byte load.
- lsh  input  1  halfword load.
- sign_ext  input  1  1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU).
- req_tag  input  TAG_W  destination-register tag.
- mem_rd_en  output  1  read request to data memory; held until mem_ack.
- mem_addr  output  32  word address, {addr[31:2],2'b00}.
- mem_ack  input  1  read data valid on mem_rdata this cycle.
- mem_rdata  input  32  memory read word.
- ld_valid  output  1  one-cycle pulse; result valid.
- ld_data  output  32  extracted and extended result.
- ld_tag  output  TAG_W  tag of the completed request.
- addr_err  output  1  qualifies ld_valid; misaligned access.
- bus_err  output  1  qualifies ld_valid; memory timeout.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- Reset values: state=IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, ld_valid=0, ld_data=0, ld_tag=0, addr_err=0, bus_err=0, timeout counter=0.
- Size decode: {lsb,lsh}=10 is byte, 01 is halfword, 00 or 11 is word.
- Handshake: a request is accepted when req_valid && req_ready. At acceptance, addr, size, sign_ext and tag are latched. Request inputs are ignored at all other times.
- Alignment check at accept:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=00 is misaligned.
  - Byte is never misaligned.
- States:
  - IDLE: req_ready=1. Accept with misaligned address goes to DONE with addr_err=1, ld_data=0, and no memory access. Accept with aligned address goes to BUS.
  - BUS: mem_rd_en=1, mem_addr = latched word address, counter increments each cycle.
    - mem_ack=1: capture the extracted result, go to DONE. Ack is legal in the first BUS cycle.
    - Counter reaching TIMEOUT without ack (TIMEOUT!=0): go to DONE with bus_err=1, ld_data=0.
    - mem_ack and timeout in the same cycle: ack wins.
  - DONE: ld_valid=1 for exactly one cycle with ld_tag, addr_err and bus_err. Then go to IDLE and clear the counter.
- Outputs between completions: ld_data and ld_tag hold their values until the next completion. addr_err and bus_err are 0 whenever ld_valid=0.
- Latency: aligned load with immediate ack returns ld_valid 2 cycles after acceptance. Misaligned load returns ld_valid 1 cycle after acceptance.
- Extraction uses little-endian lanes, byte 0 at bits [7:0]:
  - Byte offset 00/01/10/11 selects bits [7:0]/[15:8]/[23:16]/[31:24].
  - Halfword with offset[1]=0 selects [15:0]; offset[1]=1 selects [31:16].
  - Word passes through.
  - Extension fills the upper bits with the selected MSB when sign_ext=1, otherwise with zeros. Word ignores sign_ext.
- No back-to-back acceptance: req_ready is 0 in BUS and DONE. Maximum throughput is one load per 3 cycles.
- Reset mid-operation: return to IDLE next edge, drop mem_rd_en, no ld_valid. A stale mem_ack arriving in IDLE is ignored.
- mem_ack outside BUS is always ignored.

Test Plan:
- LB sign: addr=0x1003, lsb=1, sign_ext=1, mem_rdata=0x80FF1234, ack in first BUS cycle -> mem_addr=0x1000, ld_valid 2 cycles after accept, ld_data=0xFFFFFF80.
- LHU/LH: addr=0x2002, lsh=1, mem_rdata=0x9ABC5678 -> sign_ext=0 gives 0x00009ABC; sign_ext=1 gives 0xFFFF9ABC.
- Misaligned: LW addr=0x3001 -> ld_valid next cycle, addr_err=1, ld_data=0, mem_rd_en never asserted. Same for LH addr=0x3001. LB addr=0x3001 proceeds normally.
- Wait states and timeout: TIMEOUT=4, ack withheld -> mem_rd_en high 4 cycles, then ld_valid with bus_err=1. Ack on the 4th cycle instead -> normal data, bus_err=0.
- Tag and ready: back-to-back req_valid with tags 3 then 7 -> second accepted only after DONE (req_ready low 2 cycles), ld_tag=3 then 7.
- Reset in BUS: assert rst while mem_rd_en=1 -> next cycle mem_rd_en=0, req_ready=1. Ack arriving afterwards produces no ld_valid.

Source files
------------

// File: rtl/load_extract_unit_if.sv
// Load-unit bundle: request from the pipeline, word read to data memory, result to writeback.
// Pure wiring; no storage or latency of its own.
// Backpressure is carried by req_ready and by mem_ack.
interface load_extract_unit_if #(
   parameter int unsigned TAG_W = 5
);
   // request side
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_addr;
   logic             lsb;
   logic             lsh;
   logic             sign_ext;
   logic [TAG_W-1:0] req_tag;
   // data memory side
   logic             mem_rd_en;
   logic [31:0]      mem_addr;
   logic             mem_ack;
   logic [31:0]      mem_rdata;
   // writeback side
   logic             ld_valid;
   logic [31:0]      ld_data;
   logic [TAG_W-1:0] ld_tag;
   logic             addr_err;
   logic             bus_err;

   // environment view: issues requests, plays the memory, consumes results
   modport master (
      output req_valid, req_addr, lsb, lsh, sign_ext, req_tag, mem_ack, mem_rdata,
      input  req_ready, mem_rd_en, mem_addr, ld_valid, ld_data, ld_tag, addr_err, bus_err
   );

   // load unit view
   modport slave (
      input  req_valid, req_addr, lsb, lsh, sign_ext, req_tag, mem_ack, mem_rdata,
      output req_ready, mem_rd_en, mem_addr, ld_valid, ld_data, ld_tag, addr_err, bus_err
   );
endinterface

// File: rtl/load_extract_unit.sv
// Load unit: word-aligned memory read, then byte/halfword extraction with sign/zero extension.
// Latency: ld_valid 1 cycle after accept if misaligned, 1+N cycles with ack in BUS cycle N.
// Backpressure: one load in flight; req_ready low in BUS/DONE; waits on mem_ack up to TIMEOUT cycles.
module load_extract_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TAG_W   = 5
) (
   input logic                clk,
   input logic                rst,
   load_extract_unit_if.slave io
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter only needs to reach TIMEOUT-1; with TIMEOUT=0 it free-runs and is never compared.
   localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q;
   logic             req_ready_q;
   logic             mem_rd_en_q;
   logic [31:0]      mem_addr_q;
   logic             ld_valid_q;
   logic [31:0]      ld_data_q;
   logic [TAG_W-1:0] ld_tag_q;
   logic             addr_err_q;
   logic             bus_err_q;
   logic [CNT_W-1:0] cnt_q;

   // request fields captured at acceptance
   logic [1:0]       off_q;
   logic             is_byte_q;
   logic             is_half_q;
   logic             sx_q;
   logic [TAG_W-1:0] tag_q;

   logic             is_byte_d;
   logic             is_half_d;
   logic             misal_d;
   logic             timeout_d;
   logic [7:0]       byte_d;
   logic [15:0]      half_d;
   logic [31:0]      ext_d;

   // Size decode and alignment check on the live request; {lsb,lsh}=11 is treated as a word.
   always_comb begin
      is_byte_d = io.lsb & ~io.lsh;
      is_half_d = io.lsh & ~io.lsb;
      if (is_byte_d) begin
         misal_d = 1'b0;
      end else if (is_half_d) begin
         misal_d = io.req_addr[0];
      end else begin
         misal_d = (io.req_addr[1:0] != 2'b00);
      end
      timeout_d = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   end

   // Little-endian lane select on the returned word, then extension to 32 bits.
   always_comb begin
      case (off_q)
         2'b00:   byte_d = io.mem_rdata[7:0];
         2'b01:   byte_d = io.mem_rdata[15:8];
         2'b10:   byte_d = io.mem_rdata[23:16];
         default: byte_d = io.mem_rdata[31:24];
      endcase
      half_d = off_q[1] ? io.mem_rdata[31:16] : io.mem_rdata[15:0];
      if (is_byte_q) begin
         ext_d = {{24{sx_q & byte_d[7]}}, byte_d};
      end else if (is_half_q) begin
         ext_d = {{16{sx_q & half_d[15]}}, half_d};
      end else begin
         ext_d = io.mem_rdata;
      end
   end

   // Control FSM with all outputs registered; mem_ack is only looked at in BUS.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         ld_valid_q  <= 1'b0;
         ld_data_q   <= '0;
         ld_tag_q    <= '0;
         addr_err_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         cnt_q       <= '0;
         off_q       <= '0;
         is_byte_q   <= 1'b0;
         is_half_q   <= 1'b0;
         sx_q        <= 1'b0;
         tag_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io.req_valid) begin
                  off_q       <= io.req_addr[1:0];
                  is_byte_q   <= is_byte_d;
                  is_half_q   <= is_half_d;
                  sx_q        <= io.sign_ext;
                  tag_q       <= io.req_tag;
                  mem_addr_q  <= {io.req_addr[31:2], 2'b00};
                  req_ready_q <= 1'b0;
                  if (misal_d) begin
                     // misaligned: report straight away, memory is never touched
                     state_q    <= S_DONE;
                     ld_valid_q <= 1'b1;
                     addr_err_q <= 1'b1;
                     ld_data_q  <= '0;
                     ld_tag_q   <= io.req_tag;
                  end else begin
                     state_q     <= S_BUS;
                     mem_rd_en_q <= 1'b1;
                  end
               end
            end
            S_BUS: begin
               cnt_q <= cnt_q + 1'b1;
               if (io.mem_ack) begin
                  // ack beats a coincident timeout
                  state_q     <= S_DONE;
                  mem_rd_en_q <= 1'b0;
                  ld_valid_q  <= 1'b1;
                  ld_data_q   <= ext_d;
                  ld_tag_q    <= tag_q;
               end else if (timeout_d) begin
                  state_q     <= S_DONE;
                  mem_rd_en_q <= 1'b0;
                  ld_valid_q  <= 1'b1;
                  bus_err_q   <= 1'b1;
                  ld_data_q   <= '0;
                  ld_tag_q    <= tag_q;
               end
            end
            S_DONE: begin
               // ld_data/ld_tag hold; error flags only ever accompany ld_valid
               state_q     <= S_IDLE;
               ld_valid_q  <= 1'b0;
               addr_err_q  <= 1'b0;
               bus_err_q   <= 1'b0;
               cnt_q       <= '0;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               mem_rd_en_q <= 1'b0;
               ld_valid_q  <= 1'b0;
               cnt_q       <= '0;
            end
         endcase
      end
   end

   assign io.req_ready = req_ready_q;
   assign io.mem_rd_en = mem_rd_en_q;
   assign io.mem_addr  = mem_addr_q;
   assign io.ld_valid  = ld_valid_q;
   assign io.ld_data   = ld_data_q;
   assign io.ld_tag    = ld_tag_q;
   assign io.addr_err  = addr_err_q;
   assign io.bus_err   = bus_err_q;

endmodule
